axi_lite_mem_slave: RTL and testbench

Parametrised AXI4-Lite memory slave and the successor to the fixed 12-bit-address, 8-bit-data slave.
- Generalised data width with full byte-strobe support.
- Configurable memory depth with SLVERR decode for out-of-range addresses.
- Round-robin arbitration between simultaneous read and write requests.
- Saturating error counter.
- Sits behind the AXI4-Lite interconnect as a leaf target and serves as the scoreboard's reference-memory DUT.

---
 rtl/axi_lite_mem_slave.sv | 155 +++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory slave: one transaction in flight, byte-strobed writes,
// SLVERR for out-of-range addresses, round-robin read/write arbitration.
module axi_lite_mem_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 512
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [15:0]           err_count
);

    localparam int          OFFSET_BITS = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int          IDX_WIDTH   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [63:0] BYTE_RANGE  = 64'(MEM_DEPTH) * 64'(STRB_WIDTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

    state_t                state_reg;
    logic                  rr_ptr_reg;     // 0: read wins the next contested grant
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  rd_in_range;
    logic                  wr_in_range;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic                  mem_we;
    logic [STRB_WIDTH-1:0] byte_we;

    assign rd_in_range = 64'(araddr) < BYTE_RANGE;
    assign wr_in_range = 64'(waddr_reg) < BYTE_RANGE;
    assign rd_idx      = IDX_WIDTH'(araddr >> OFFSET_BITS);
    assign wr_idx      = IDX_WIDTH'(waddr_reg >> OFFSET_BITS);

    // Reset on the handshake edge wins, so an aborted write never lands.
    assign mem_we = (state_reg == WDATA) && wready && wvalid && wr_in_range && !reset;

    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_byte_we
            assign byte_we[gi] = mem_we && wstrb[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (byte_we[b]) begin
                mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
            waddr_reg  <= '0;
            arready    <= 1'b0;
            awready    <= 1'b0;
            wready     <= 1'b0;
            rvalid     <= 1'b0;
            bvalid     <= 1'b0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
            bresp      <= RESP_OKAY;
            err_count  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arvalid && awvalid) begin
                        rr_ptr_reg <= !rr_ptr_reg;
                        if (!rr_ptr_reg) begin
                            state_reg <= RADDR;
                            arready   <= 1'b1;
                        end else begin
                            state_reg <= WADDR;
                            awready   <= 1'b1;
                        end
                    end else if (arvalid) begin
                        state_reg <= RADDR;
                        arready   <= 1'b1;
                    end else if (awvalid) begin
                        state_reg <= WADDR;
                        awready   <= 1'b1;
                    end
                end
                RADDR: begin
                    arready   <= 1'b0;
                    rvalid    <= 1'b1;
                    rdata     <= rd_in_range ? mem[rd_idx] : '0;
                    rresp     <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    state_reg <= RDATA;
                    if (!rd_in_range) begin
                        err_count <= sat_inc(err_count);
                    end
                end
                RDATA: begin
                    if (rready) begin
                        rvalid    <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                WADDR: begin
                    awready   <= 1'b0;
                    waddr_reg <= awaddr;
                    wready    <= 1'b1;
                    state_reg <= WDATA;
                end
                WDATA: begin
                    if (wvalid) begin
                        wready    <= 1'b0;
                        bvalid    <= 1'b1;
                        bresp     <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        state_reg <= WRESP;
                        if (!wr_in_range) begin
                            err_count <= sat_inc(err_count);
                        end
                    end
                end
                WRESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave (32-bit and 8-bit instances); responses
// are checked by a queue-based monitor independent of the stimulus process.
module tb_axi_lite_mem_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        use8;
    logic [11:0] araddr, awaddr;
    logic        arvalid, awvalid, wvalid, rready, bready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        d32_arvalid, d32_awvalid, d32_wvalid;
    logic        d32_arready, d32_rvalid, d32_awready, d32_wready, d32_bvalid;
    logic [31:0] d32_rdata;
    logic [1:0]  d32_rresp, d32_bresp;
    logic [15:0] d32_err_count;

    logic        d8_arvalid, d8_awvalid, d8_wvalid;
    logic        d8_arready, d8_rvalid, d8_awready, d8_wready, d8_bvalid;
    logic [7:0]  d8_rdata;
    logic [1:0]  d8_rresp, d8_bresp;
    logic [15:0] d8_err_count;

    logic        arready, awready, wready, rvalid, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic [15:0] err_count;

    assign d32_arvalid = arvalid && !use8;
    assign d32_awvalid = awvalid && !use8;
    assign d32_wvalid  = wvalid  && !use8;
    assign d8_arvalid  = arvalid && use8;
    assign d8_awvalid  = awvalid && use8;
    assign d8_wvalid   = wvalid  && use8;

    assign arready   = use8 ? d8_arready : d32_arready;
    assign awready   = use8 ? d8_awready : d32_awready;
    assign wready    = use8 ? d8_wready  : d32_wready;
    assign rvalid    = use8 ? d8_rvalid  : d32_rvalid;
    assign bvalid    = use8 ? d8_bvalid  : d32_bvalid;
    assign rdata     = use8 ? {24'h0, d8_rdata} : d32_rdata;
    assign rresp     = use8 ? d8_rresp : d32_rresp;
    assign bresp     = use8 ? d8_bresp : d32_bresp;
    assign err_count = use8 ? d8_err_count : d32_err_count;

    axi_lite_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(512)) u_dut32 (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(d32_arvalid), .arready(d32_arready),
        .rdata(d32_rdata), .rresp(d32_rresp), .rvalid(d32_rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(d32_awvalid), .awready(d32_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(d32_wvalid), .wready(d32_wready),
        .bresp(d32_bresp), .bvalid(d32_bvalid), .bready(bready),
        .err_count(d32_err_count)
    );

    axi_lite_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(512)) u_dut8 (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(d8_arvalid), .arready(d8_arready),
        .rdata(d8_rdata), .rresp(d8_rresp), .rvalid(d8_rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(d8_awvalid), .awready(d8_awready),
        .wdata(wdata[7:0]), .wstrb(wstrb[0:0]), .wvalid(d8_wvalid), .wready(d8_wready),
        .bresp(d8_bresp), .bvalid(d8_bvalid), .bready(bready),
        .err_count(d8_err_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [1:0]  wr_q[$];
    logic [31:0] exp_mem [512];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (!use8 && addr < 12'h800) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) exp_mem[addr[10:2]][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    // Scoreboard monitor: every R/B handshake pops and compares one expectation.
    always @(negedge clock) begin
        rd_exp_t e;
        logic [1:0] br;
        if (rvalid && rready) begin
            if (rd_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_r: got rvalid=1 rdata=0x%08h, want no response", rdata);
            end else begin
                e = rd_q.pop_front();
                $display("R  rdata=0x%08h rresp=%0b (want 0x%08h/%0b)", rdata, rresp, e.data, e.resp);
                check("rdata", rdata, e.data);
                check("rresp", 32'(rresp), 32'(e.resp));
            end
        end
        if (bvalid && bready) begin
            if (wr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_b: got bvalid=1 bresp=%0b, want no response", bresp);
            end else begin
                br = wr_q.pop_front();
                $display("B  bresp=%0b (want %0b)", bresp, br);
                check("bresp", 32'(bresp), 32'(br));
            end
        end
    end

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp, input int hold);
        int n;
        wr_q.push_back(resp);
        if (resp == OKAY) model_write(addr, data, strb);
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = (hold == 0);
        n = 0;
        while (!awready && n < 10) begin tick(); n++; end
        check("aw_latency", 32'(n), 32'd1);
        tick();
        awvalid = 1'b0;
        n = 0;
        while (!wready && n < 10) begin tick(); n++; end
        check("wready_up", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0;
        check("bvalid_up", 32'(bvalid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), 32'(resp));
            check("awready_quiet", 32'(awready), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        check("bvalid_down", 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int hold);
        int n;
        rd_q.push_back('{data: data, resp: resp});
        araddr = addr; arvalid = 1'b1;
        rready = (hold == 0);
        n = 0;
        while (!arready && n < 10) begin tick(); n++; end
        check("ar_latency", 32'(n), 32'd1);
        tick();
        arvalid = 1'b0;
        check("rvalid_2cyc", 32'(rvalid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, data);
            check("rresp_hold", 32'(rresp), 32'(resp));
            check("arready_quiet", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        check("rvalid_down", 32'(rvalid), 32'd0);
    endtask

    // Both requests raised together; the loser is withdrawn after the grant.
    task automatic contest(input logic exp_rd, input logic [11:0] addr, input logic [31:0] data);
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        araddr = addr; awaddr = addr; wdata = data; wstrb = 4'hF;
        rready = 1'b1; bready = 1'b1;
        tick();
        check("grant_ar", 32'(arready), 32'(exp_rd));
        check("grant_aw", 32'(awready), 32'(!exp_rd));
        if (arready) begin
            rd_q.push_back('{data: exp_mem[addr[10:2]], resp: OKAY});
            tick();
            arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
            tick();
        end else if (awready) begin
            wr_q.push_back(OKAY);
            model_write(addr, data, 4'hF);
            tick();
            arvalid = 1'b0; awvalid = 1'b0;
            tick();
            wvalid = 1'b0;
            tick();
        end else begin
            arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rresp", 32'(rresp), 32'(OKAY));
        check("rst_bresp", 32'(bresp), 32'(OKAY));
        check("rst_err_count", 32'(err_count), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: still running at t=%0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; use8 = 1'b0;
        araddr = '0; awaddr = '0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        wdata = '0; wstrb = '0; rready = 1'b1; bready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_outputs();

        for (int i = 0; i < 512; i++) begin
            do_write(12'(i * 4), 32'h5A5A_0000 + 32'(i) * 32'h0001_0003, 4'hF, OKAY, 0);
        end

        // Basic write/read and partial strobes
        do_write(12'h010, 32'hDEADBEEF, 4'hF, OKAY, 0);
        do_read(12'h010, 32'hDEADBEEF, OKAY, 0);
        do_write(12'h020, 32'h11223344, 4'hF, OKAY, 0);
        do_write(12'h020, 32'hAABBCCDD, 4'h5, OKAY, 0);
        do_read(12'h020, 32'h11BB33DD, OKAY, 0);
        do_write(12'h024, 32'hCAFEF00D, 4'h0, OKAY, 0);
        do_read(12'h024, exp_mem[9], OKAY, 0);
        do_read(12'h013, 32'hDEADBEEF, OKAY, 0);

        // Round-robin: read, write, read
        contest(1'b1, 12'h010, 32'h0BAD0BAD);
        contest(1'b0, 12'h030, 32'h01234567);
        contest(1'b1, 12'h030, 32'hFFFFFFFF);
        do_read(12'h030, 32'h01234567, OKAY, 0);

        // Out-of-range accesses
        check("err_before", 32'(err_count), 32'd0);
        do_write(12'h800, 32'hBADC0DE5, 4'hF, SLVERR, 0);
        do_read(12'hFFC, 32'h0, SLVERR, 0);
        check("err_after", 32'(err_count), 32'd2);
        for (int i = 0; i < 512; i++) begin
            do_read(12'(i * 4), exp_mem[i], OKAY, 0);
        end

        // Backpressure on R and B
        do_read(12'h010, 32'hDEADBEEF, OKAY, 5);
        do_write(12'h044, 32'h13572468, 4'hF, OKAY, 5);
        do_read(12'h044, 32'h13572468, OKAY, 0);

        // Reset while waiting in WDATA
        awaddr = 12'h040; awvalid = 1'b1; wvalid = 1'b0;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; bready = 1'b1;
        n = 0;
        while (!awready && n < 10) begin tick(); n++; end
        check("aw_latency", 32'(n), 32'd1);
        tick();
        awvalid = 1'b0;
        check("wready_up", 32'(wready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs();
        do_read(12'h040, exp_mem[16], OKAY, 0);
        contest(1'b1, 12'h044, 32'h0);

        // 8-bit data width instance
        use8 = 1'b1;
        do_write(12'h010, 32'h000000A5, 4'h1, OKAY, 0);
        do_read(12'h010, 32'h000000A5, OKAY, 0);
        do_write(12'h1FF, 32'h0000003C, 4'h1, OKAY, 0);
        do_read(12'h1FF, 32'h0000003C, OKAY, 0);
        do_read(12'h200, 32'h0, SLVERR, 0);
        check("err8", 32'(err_count), 32'd1);

        repeat (2) tick();
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
